// File: rtl/fifo_tree_pkg.sv
// Shared definitions for the clause FIFO tree consumer.
// Holds the default clause width and the reader controller state encoding.
package fifo_tree_pkg;

  localparam int CLAUSE_WIDTH_DEF = 36;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_tree_reader_skid_fifo.sv
// skid_fifo: small circular buffer that absorbs clauses already requested
// from the tree while the sink is stalled.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   clear          drops all entries (pointers and occupancy to zero)
//   push/push_data write one entry at the tail
//   pop            remove the head entry (ignored when empty)
//   head_data      current head entry
//   occupancy      number of stored entries
module skid_fifo #(
  parameter int DATA_WIDTH = 36,
  parameter int DEPTH      = 2,
  localparam int OCC_W     = $clog2(DEPTH + 1),
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_W-1:0]      occupancy
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [OCC_W-1:0]      occ_r;
  logic                  do_pop_s;

  // Pointer increment with wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign do_pop_s  = pop && (occ_r != {OCC_W{1'b0}});
  assign head_data = mem_r[rd_ptr_r];
  assign occupancy = occ_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      occ_r <= occ_r + OCC_W'(push) - OCC_W'(do_pop_s);
    end
  end

endmodule

// File: rtl/fifo_tree_reader.sv
// fifo_tree_reader: drains the clause FIFO tree output port and presents
// clauses on a valid/ready stream. Read latency is hidden by a skid buffer
// whose free space is the credit for new pops. A flush sequence empties the
// tree and pulses clear-overflow when done.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   fifo_empty_i      tree empty flag
//   fifo_clause_i     tree output data
//   fifo_of_i         tree overflow flag
//   fifo_rden_o       pop request to the tree
//   fifo_cof_o        one-cycle clear-overflow pulse
//   clause_o          head clause
//   clause_valid_o    clause_o valid
//   clause_ready_i    sink accepts
//   flush_i           flush request (RUN only)
//   flush_done_o      one-cycle flush completion pulse
//   of_seen_o         sticky overflow flag since last flush
//   pop_count_o       saturating transfer count
module fifo_tree_reader
  import fifo_tree_pkg::*;
#(
  parameter int CLAUSE_WIDTH = CLAUSE_WIDTH_DEF,
  parameter int READ_LATENCY = 1,
  parameter int SKID_DEPTH   = READ_LATENCY + 1,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fifo_empty_i,
  input  logic [CLAUSE_WIDTH-1:0] fifo_clause_i,
  input  logic                    fifo_of_i,
  output logic                    fifo_rden_o,
  output logic                    fifo_cof_o,
  output logic [CLAUSE_WIDTH-1:0] clause_o,
  output logic                    clause_valid_o,
  input  logic                    clause_ready_i,
  input  logic                    flush_i,
  output logic                    flush_done_o,
  output logic                    of_seen_o,
  output logic [COUNT_WIDTH-1:0]  pop_count_o
);

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);

  state_e                  state_r;
  state_e                  state_nxt_s;
  logic [READ_LATENCY-1:0] inflight_r;
  logic [OCC_W-1:0]        inflight_cnt_s;
  logic [OCC_W-1:0]        occ_s;
  logic [OCC_W:0]          credit_s;
  logic                    valid_s;
  logic                    xfer_s;
  logic                    push_s;
  logic                    flush_enter_s;
  logic                    flush_exit_s;
  logic                    cof_r;
  logic                    of_seen_r;
  logic [COUNT_WIDTH-1:0]  pop_count_r;

  assign valid_s       = (state_r == RUN) && (occ_s != {OCC_W{1'b0}});
  assign xfer_s        = valid_s && clause_ready_i;
  // Response at the tail of the latency pipe is kept only while running.
  assign push_s        = inflight_r[READ_LATENCY-1] && (state_r == RUN);
  assign flush_enter_s = (state_r == RUN) && (state_nxt_s == FLUSH);
  assign flush_exit_s  = (state_r == FLUSH) && (state_nxt_s == RUN);
  // Entries that will remain or arrive; must stay below SKID_DEPTH to pop.
  assign credit_s      = {1'b0, occ_s} - (OCC_W + 1)'(xfer_s) + {1'b0, inflight_cnt_s};

  // Count outstanding tree reads.
  always_comb begin
    inflight_cnt_s = {OCC_W{1'b0}};
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_cnt_s = inflight_cnt_s + OCC_W'(inflight_r[i]);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (flush_i) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH: begin
        if (fifo_empty_i && (inflight_cnt_s == {OCC_W{1'b0}}) && !fifo_rden_o) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // Pop request: credit-limited while running, unconditional while flushing.
  always_comb begin
    fifo_rden_o = 1'b0;
    case (state_r)
      RUN:     fifo_rden_o = !reset && !fifo_empty_i && (credit_s < (OCC_W + 1)'(SKID_DEPTH));
      FLUSH:   fifo_rden_o = !reset && !fifo_empty_i;
      default: fifo_rden_o = 1'b0;
    endcase
  end

  // In-flight shift register, completion pulse, overflow flag, pop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_r  <= {READ_LATENCY{1'b0}};
      cof_r       <= 1'b0;
      of_seen_r   <= 1'b0;
      pop_count_r <= {COUNT_WIDTH{1'b0}};
    end else begin
      inflight_r <= (inflight_r << 1) | READ_LATENCY'(fifo_rden_o);
      cof_r      <= flush_exit_s;
      if (fifo_of_i) begin
        of_seen_r <= 1'b1;
      end else if (flush_exit_s) begin
        of_seen_r <= 1'b0;
      end
      if (xfer_s && (pop_count_r != {COUNT_WIDTH{1'b1}})) begin
        pop_count_r <= pop_count_r + COUNT_WIDTH'(1);
      end
    end
  end

  skid_fifo #(
    .DATA_WIDTH (CLAUSE_WIDTH),
    .DEPTH      (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush_enter_s),
    .push      (push_s),
    .push_data (fifo_clause_i),
    .pop       (xfer_s),
    .head_data (clause_o),
    .occupancy (occ_s)
  );

  assign clause_valid_o = valid_s;
  assign fifo_cof_o     = cof_r;
  assign flush_done_o   = cof_r;
  assign of_seen_o      = of_seen_r;
  assign pop_count_o    = pop_count_r;

endmodule

// File: tb/tb_fifo_tree_reader.sv
// Directed bench: dut0 (READ_LATENCY=1, COUNT_WIDTH=4), dut1 (READ_LATENCY=2).
// A behavioural tree (queue + latency pipe) feeds the active DUT; a small
// reference of the skid contents predicts every output each cycle.
module tb_fifo_tree_reader;

  logic        clk = 1'b0;
  logic        rst     [2];
  logic        empty_i [2];
  logic [35:0] cl_i    [2];
  logic        of_i    [2];
  logic        ready   [2];
  logic        flush   [2];
  logic        rden    [2];
  logic        cof     [2];
  logic        valid   [2];
  logic        done    [2];
  logic        ofs     [2];
  logic [35:0] cl_o    [2];
  logic [3:0]  pc0;
  logic [15:0] pc1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  int          sel;
  bit          run;
  bit          pv   [2];
  logic [35:0] pipe [2];
  logic [35:0] q    [$];
  logic [35:0] sb   [$];
  logic [15:0] pc_m;
  bit          ofs_m, pulse_m;
  bit          rdy_cur, flush_cur, of_cur, of_on_done;
  int          cyc, first_rden, first_xfer, last_xfer, xfers, flush_pops, pulses, cof_cnt;

  always #5 clk = ~clk;

  fifo_tree_reader #(.READ_LATENCY(1), .COUNT_WIDTH(4)) dut0 (
    .clk(clk), .reset(rst[0]), .fifo_empty_i(empty_i[0]), .fifo_clause_i(cl_i[0]),
    .fifo_of_i(of_i[0]), .fifo_rden_o(rden[0]), .fifo_cof_o(cof[0]), .clause_o(cl_o[0]),
    .clause_valid_o(valid[0]), .clause_ready_i(ready[0]), .flush_i(flush[0]),
    .flush_done_o(done[0]), .of_seen_o(ofs[0]), .pop_count_o(pc0));

  fifo_tree_reader #(.READ_LATENCY(2), .COUNT_WIDTH(16)) dut1 (
    .clk(clk), .reset(rst[1]), .fifo_empty_i(empty_i[1]), .fifo_clause_i(cl_i[1]),
    .fifo_of_i(of_i[1]), .fifo_rden_o(rden[1]), .fifo_cof_o(cof[1]), .clause_o(cl_o[1]),
    .clause_valid_o(valid[1]), .clause_ready_i(ready[1]), .flush_i(flush[1]),
    .flush_done_o(done[1]), .of_seen_o(ofs[1]), .pop_count_o(pc1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic start_phase();
    cyc = 0; first_rden = -1; first_xfer = -1; last_xfer = -1;
    xfers = 0; flush_pops = 0; pulses = 0; cof_cnt = 0;
  endtask

  // One clock cycle: drive inputs, check outputs, advance the reference.
  task automatic cycle();
    int rl, skid, infl, cred;
    bit xf, r, comp, push;
    logic [15:0] pcmax, pco;
    rl    = (sel == 1) ? 2 : 1;
    skid  = rl + 1;
    pcmax = (sel == 1) ? 16'hFFFF : 16'h000F;
    @(negedge clk);
    infl = int'(pv[0]) + ((rl == 2) ? int'(pv[1]) : 0);
    comp = !run && (q.size() == 0) && (infl == 0);
    empty_i[sel] = (q.size() == 0);
    cl_i[sel]    = pv[rl-1] ? pipe[rl-1] : 36'd0;
    ready[sel]   = rdy_cur;
    flush[sel]   = flush_cur;
    of_i[sel]    = of_cur | (of_on_done & comp);
    #1;
    pco = (sel == 1) ? pc1 : {12'd0, pc0};
    check("valid", valid[sel], run && (sb.size() != 0));
    check("cof", cof[sel], pulse_m);
    check("flush_done", done[sel], pulse_m);
    check("of_seen", ofs[sel], ofs_m);
    check("pop_count", pco, pc_m);
    if (run && sb.size() != 0) check("clause", cl_o[sel], sb[0]);
    xf   = run && (sb.size() != 0) && rdy_cur;
    cred = sb.size() - int'(xf) + infl;
    r    = run ? ((q.size() != 0) && (cred < skid)) : (q.size() != 0);
    check("rden", rden[sel], r);
    if (cof[sel]) cof_cnt++;
    if (rden[sel] && first_rden < 0) first_rden = cyc;
    if (!run && rden[sel]) flush_pops++;
    if (xf) begin
      xfers++;
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
      void'(sb.pop_front());
    end
    push = pv[rl-1] && run;
    if (push) sb.push_back(pipe[rl-1]);
    pulse_m = 1'b0;
    if (of_i[sel]) ofs_m = 1'b1;
    else if (comp) ofs_m = 1'b0;
    if (xf && pc_m != pcmax) pc_m++;
    if (run && flush_cur) begin
      run = 1'b0;
      sb.delete();
    end else if (comp) begin
      run = 1'b1;
      pulse_m = 1'b1;
      pulses++;
    end
    if (rl == 2) begin
      pipe[1] = pipe[0];
      pv[1]   = pv[0];
    end
    pv[0]   = rden[sel];
    pipe[0] = (rden[sel] && q.size() != 0) ? q.pop_front() : 36'd0;
    flush_cur = 1'b0;
    of_cur    = 1'b0;
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      cycle();
      n++;
      busy = (q.size() != 0) || pv[0] || pv[1] || (sb.size() != 0) || !run;
    end
    check("drain_timeout", busy, 1'b0);
    repeat (2) cycle();
  endtask

  task automatic do_reset(input int d);
    sel = d;
    rst[d] = 1'b1;
    empty_i[d] = 1'b1; cl_i[d] = 36'd0; of_i[d] = 1'b0; ready[d] = 1'b0; flush[d] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst[d] = 1'b0;
    #1;
    check("rst_rden", rden[d], 1'b0);
    check("rst_cof", cof[d], 1'b0);
    check("rst_clause", cl_o[d], 36'd0);
    check("rst_valid", valid[d], 1'b0);
    check("rst_done", done[d], 1'b0);
    check("rst_of_seen", ofs[d], 1'b0);
    check("rst_pop_count", (d == 1) ? pc1 : {12'd0, pc0}, 16'd0);
    run = 1'b1; pv[0] = 1'b0; pv[1] = 1'b0; pipe[0] = 36'd0; pipe[1] = 36'd0;
    sb.delete(); pc_m = 16'd0; ofs_m = 1'b0; pulse_m = 1'b0;
    rdy_cur = 1'b0; flush_cur = 1'b0; of_cur = 1'b0; of_on_done = 1'b0;
    start_phase();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; empty_i[i] = 1'b1; cl_i[i] = 36'd0; of_i[i] = 1'b0;
      ready[i] = 1'b0; flush[i] = 1'b0;
    end

    // Reset and 5-clause stream at full rate
    do_reset(0);
    for (int i = 1; i <= 5; i++) q.push_back(36'(i));
    rdy_cur = 1'b1;
    drain(40);
    check("t1_latency", first_xfer - first_rden, 2);
    check("t1_span", last_xfer - first_xfer, 4);
    check("t1_xfers", xfers, 5);
    check("t1_pop_count", pc0, 4'd5);

    // Ready pattern 1,0,0 repeating
    start_phase();
    for (int i = 6; i <= 10; i++) q.push_back(36'(i));
    for (int n = 0; n < 60; n++) begin
      rdy_cur = (n % 3 == 0);
      cycle();
    end
    check("t2_xfers", xfers, 5);
    check("t2_pop_count", pc0, 4'd10);

    // Saturation of the 4-bit counter
    start_phase();
    for (int i = 11; i <= 18; i++) q.push_back(36'(i));
    rdy_cur = 1'b1;
    drain(40);
    check("t3_xfers", xfers, 8);
    check("t3_pop_count_sat", pc0, 4'hF);

    // Overflow, then flush with 7 queued and 2 in the skid
    start_phase();
    rdy_cur = 1'b0;
    of_cur = 1'b1;
    cycle();
    for (int i = 0; i < 9; i++) q.push_back(36'h100 + 36'(i));
    for (int n = 0; n < 10 && !(sb.size() == 2 && !pv[0]); n++) cycle();
    check("t5_skid_fill", sb.size(), 2);
    check("t5_tree_left", q.size(), 7);
    flush_cur = 1'b1;
    cycle();
    flush_pops = 0; cof_cnt = 0;
    drain(30);
    check("t5_flush_pops", flush_pops, 7);
    check("t5_cof_pulses", cof_cnt, 1);
    check("t5_of_seen_clr", ofs[0], 1'b0);

    // Overflow coincident with flush completion keeps of_seen
    start_phase();
    of_on_done = 1'b1;
    for (int i = 0; i < 3; i++) q.push_back(36'h300 + 36'(i));
    cycle();
    flush_cur = 1'b1;
    cycle();
    drain(30);
    of_on_done = 1'b0;
    check("t6_of_seen_set_wins", ofs[0], 1'b1);

    // Reset in the middle of a flush
    start_phase();
    for (int i = 0; i < 4; i++) q.push_back(36'h400 + 36'(i));
    flush_cur = 1'b1;
    repeat (3) cycle();
    q.delete();
    do_reset(0);
    repeat (4) cycle();
    check("t7_cof_pulses", cof_cnt, 0);

    // READ_LATENCY=2: throughput, then credit limit under stall
    do_reset(1);
    for (int i = 0; i < 20; i++) q.push_back(36'h200 + 36'(i));
    rdy_cur = 1'b1;
    drain(80);
    check("t4_latency", first_xfer - first_rden, 3);
    check("t4_span", last_xfer - first_xfer, 19);
    check("t4_pop_count", pc1, 16'd20);
    start_phase();
    for (int i = 0; i < 8; i++) q.push_back(36'h280 + 36'(i));
    rdy_cur = 1'b0;
    repeat (8) cycle();
    check("t4_skid_full", sb.size(), 3);
    check("t4_tree_held", q.size(), 5);
    rdy_cur = 1'b1;
    drain(40);
    check("t4_stall_xfers", xfers, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
